// File: rtl/xmpl_dsp_job_sched_if.sv
// Requester and DSP-stage handshake bundle for the job scheduler.
interface xmpl_dsp_job_sched_if #(
  parameter int unsigned NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0] req_i;
  logic [2:0]         stage_mask_i;
  logic [NUM_REQ-1:0] ack_o;
  logic [NUM_REQ-1:0] done_o;
  logic [NUM_REQ-1:0] err_o;
  logic               cic_status_i;
  logic               fft_status_i;
  logic               flt_status_i;
  logic               en_cic_o;
  logic               en_fft_o;
  logic               en_flt_o;

  modport master (
    output req_i, stage_mask_i, cic_status_i, fft_status_i, flt_status_i,
    input  ack_o, done_o, err_o, en_cic_o, en_fft_o, en_flt_o
  );

  modport slave (
    input  req_i, stage_mask_i, cic_status_i, fft_status_i, flt_status_i,
    output ack_o, done_o, err_o, en_cic_o, en_fft_o, en_flt_o
  );
endinterface

// File: rtl/xmpl_dsp_job_sched.sv
// Round-robin job scheduler: grants one requester at a time and sequences the
// enabled DSP stages CIC -> FFT -> FLT, each guarded by a timeout.
module xmpl_dsp_job_sched #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                en_i,
  xmpl_dsp_job_sched_if.slave bus_io,
  output logic                busy_o,
  output logic [2:0]          state_o,
  output logic [CNT_W-1:0]    job_cnt_o
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TW  = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StGrant = 3'd1,
    StCic   = 3'd2,
    StFft   = 3'd3,
    StFlt   = 3'd4,
    StDone  = 3'd5,
    StErr   = 3'd6
  } state_e;

  state_e             r_state, w_state_next;
  logic [IdW-1:0]     r_id, r_last_id, w_win_id, w_cand;
  logic               w_win_found;
  logic [2:0]         r_mask;
  logic [TW-1:0]      r_stage_cnt;
  logic [CNT_W-1:0]   r_job_cnt;
  logic               w_timeout;
  logic [NUM_REQ-1:0] w_id_oh;

  // Search upward from the requester after the last winner, wrapping.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = r_last_id;
    w_cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_cand = IdW'((32'(r_last_id) + 32'd1 + i) % NUM_REQ);
      if (!w_win_found && bus_io.req_i[w_cand]) begin
        w_win_found = 1'b1;
        w_win_id    = w_cand;
      end
    end
  end

  assign w_timeout = (r_stage_cnt == TW'(TIMEOUT_CYC - 1));

  // Status is checked before timeout so a same-cycle status still completes.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (en_i && (|bus_io.req_i)) w_state_next = StGrant;
      StGrant: begin
        if (r_mask[0])      w_state_next = StCic;
        else if (r_mask[1]) w_state_next = StFft;
        else if (r_mask[2]) w_state_next = StFlt;
        else                w_state_next = StDone;
      end
      StCic: begin
        if (bus_io.cic_status_i) begin
          if (r_mask[1])      w_state_next = StFft;
          else if (r_mask[2]) w_state_next = StFlt;
          else                w_state_next = StDone;
        end else if (w_timeout) begin
          w_state_next = StErr;
        end
      end
      StFft: begin
        if (bus_io.fft_status_i) w_state_next = r_mask[2] ? StFlt : StDone;
        else if (w_timeout)      w_state_next = StErr;
      end
      StFlt: begin
        if (bus_io.flt_status_i) w_state_next = StDone;
        else if (w_timeout)      w_state_next = StErr;
      end
      StDone:  w_state_next = StIdle;
      StErr:   w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state     <= StIdle;
      r_id        <= '0;
      r_last_id   <= IdW'(NUM_REQ - 1);
      r_mask      <= '0;
      r_stage_cnt <= '0;
      r_job_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && w_state_next == StGrant) begin
        r_id   <= w_win_id;
        r_mask <= bus_io.stage_mask_i;
      end
      if (r_state == StGrant) r_last_id <= r_id;
      if (w_state_next != r_state) begin
        r_stage_cnt <= '0;
      end else if (r_state inside {StCic, StFft, StFlt}) begin
        r_stage_cnt <= r_stage_cnt + TW'(1);
      end
      if (r_state == StDone) r_job_cnt <= r_job_cnt + CNT_W'(1);
    end
  end

  assign w_id_oh         = NUM_REQ'(1) << r_id;
  assign bus_io.ack_o    = (r_state == StGrant) ? w_id_oh : '0;
  assign bus_io.done_o   = (r_state == StDone) ? w_id_oh : '0;
  assign bus_io.err_o    = (r_state == StErr) ? w_id_oh : '0;
  assign bus_io.en_cic_o = (r_state == StCic);
  assign bus_io.en_fft_o = (r_state == StFft);
  assign bus_io.en_flt_o = (r_state == StFlt);
  assign busy_o          = (r_state != StIdle);
  assign state_o         = r_state;
  assign job_cnt_o       = r_job_cnt;

endmodule

// File: tb/tb_xmpl_dsp_job_sched.sv
// Scoreboard bench for xmpl_dsp_job_sched: expected ack/done/err pulses are queued by
// the stimulus and matched by an independent monitor; stage timing checked from a log.
module tb_xmpl_dsp_job_sched;
  localparam int unsigned NR = 4;
  localparam int unsigned TO = 8;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          en;
  logic          busy;
  logic [2:0]    state;
  logic [CW-1:0] job_cnt;

  xmpl_dsp_job_sched_if #(.NUM_REQ(NR)) bus ();

  xmpl_dsp_job_sched #(
    .NUM_REQ    (NR),
    .TIMEOUT_CYC(TO),
    .CNT_W      (CW)
  ) dut (
    .clk_i    (clk),
    .reset_n_i(reset_n),
    .en_i     (en),
    .bus_io   (bus.slave),
    .busy_o   (busy),
    .state_o  (state),
    .job_cnt_o(job_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    kind;  // 0 ack, 1 done, 2 err
    logic [NR-1:0] vec;
  } evt_t;

  evt_t       exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         resp_delay = 1000;
  logic       log_en = 1'b0;
  logic [2:0] st_log[$];
  logic [2:0] en_log[$];
  logic       ack_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_evt(input logic [1:0] k, input logic [NR-1:0] v);
    exp_q.push_back({k, v});
  endtask

  // Monitor: every pulse the DUT presents is matched against the next expected event.
  always @(negedge clk) begin : monitor
    evt_t obs;
    logic seen;
    seen = 1'b1;
    obs  = '0;
    if (|bus.ack_o)       obs = {2'd0, bus.ack_o};
    else if (|bus.done_o) obs = {2'd1, bus.done_o};
    else if (|bus.err_o)  obs = {2'd2, bus.err_o};
    else                  seen = 1'b0;
    if (seen) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: got %0h expected none", obs);
      end else begin
        chk("event", 32'(obs), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin : logger
    if (log_en) begin
      st_log.push_back(state);
      en_log.push_back({bus.en_flt_o, bus.en_fft_o, bus.en_cic_o});
      ack_log.push_back(|bus.ack_o);
    end
  end

  // Stage model: raise status once the enable has been high for more than resp_delay cycles.
  initial begin : responder
    int c0, c1, c2;
    c0 = 0; c1 = 0; c2 = 0;
    bus.cic_status_i = 1'b0;
    bus.fft_status_i = 1'b0;
    bus.flt_status_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      c0 = bus.en_cic_o ? c0 + 1 : 0;
      c1 = bus.en_fft_o ? c1 + 1 : 0;
      c2 = bus.en_flt_o ? c2 + 1 : 0;
      bus.cic_status_i = bus.en_cic_o && (c0 > resp_delay);
      bus.fft_status_i = bus.en_fft_o && (c1 > resp_delay);
      bus.flt_status_i = bus.en_flt_o && (c2 > resp_delay);
    end
  end

  function automatic int en_count(input int b);
    int n = 0;
    foreach (en_log[i]) if (en_log[i][b]) n++;
    return n;
  endfunction

  function automatic int first_hi(input int b);
    foreach (en_log[i]) if (en_log[i][b]) return i;
    return -1;
  endfunction

  function automatic int last_hi(input int b);
    int r = -1;
    foreach (en_log[i]) if (en_log[i][b]) r = i;
    return r;
  endfunction

  function automatic int overlap_count();
    int n = 0;
    foreach (en_log[i]) if ($countones(en_log[i]) > 1) n++;
    return n;
  endfunction

  function automatic int st_count(input logic [2:0] v);
    int n = 0;
    foreach (st_log[i]) if (st_log[i] == v) n++;
    return n;
  endfunction

  // Distinct consecutive states packed as hex nibbles, e.g. 0,1,2,5,0 -> 'h01250.
  function automatic logic [31:0] st_seq();
    logic [31:0] s = '0;
    foreach (st_log[i]) if (i == 0 || st_log[i] != st_log[i-1]) s = (s << 4) | 32'(st_log[i]);
    return s;
  endfunction

  task automatic start_log();
    st_log.delete();
    en_log.delete();
    ack_log.delete();
    log_en = 1'b1;
  endtask

  task automatic do_job(input logic [NR-1:0] r, input logic [2:0] m, input int tail);
    logic got;
    got = 1'b0;
    bus.req_i        = r;
    bus.stage_mask_i = m;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = |bus.ack_o;
    end
    chk("ack_within_bound", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    bus.req_i = '0;
    repeat (tail) @(posedge clk);
    #1;
  endtask

  initial begin : stim
    int acks;
    int idx[$];
    reset_n          = 1'b0;
    en               = 1'b1;
    bus.req_i        = '0;
    bus.stage_mask_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pulses", 32'({bus.ack_o, bus.done_o, bus.err_o}), 32'd0);
    chk("rst_enables", 32'({bus.en_cic_o, bus.en_fft_o, bus.en_flt_o}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_job_cnt", 32'(job_cnt), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Single full job, status 3 cycles after each enable.
    push_evt(2'd0, 4'b0001);
    push_evt(2'd1, 4'b0001);
    resp_delay = 3;
    start_log();
    do_job(4'b0001, 3'b111, 16);
    log_en = 1'b0;
    chk("t1_state_seq", st_seq(), 32'h0123450);
    chk("t1_cic_cycles", 32'(en_count(0)), 32'd4);
    chk("t1_fft_cycles", 32'(en_count(1)), 32'd4);
    chk("t1_flt_cycles", 32'(en_count(2)), 32'd4);
    chk("t1_overlap", 32'(overlap_count()), 32'd0);
    chk("t1_job_cnt", 32'(job_cnt), 32'd1);

    // Fairness from reset: all requesters held, empty mask.
    reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      push_evt(2'd0, 4'b0001 << (i % 4));
      push_evt(2'd1, 4'b0001 << (i % 4));
    end
    start_log();
    bus.stage_mask_i = 3'b000;
    bus.req_i        = 4'hF;
    acks             = 0;
    for (int i = 0; i < 40 && acks < 5; i++) begin
      @(negedge clk);
      if (|bus.ack_o) acks++;
    end
    chk("t2_ack_count", 32'(acks), 32'd5);
    @(posedge clk);
    #1 bus.req_i = '0;
    repeat (4) @(posedge clk);
    #1 log_en = 1'b0;
    foreach (ack_log[i]) if (ack_log[i]) idx.push_back(i);
    for (int i = 1; i < idx.size(); i++) chk("t2_ack_gap", 32'(idx[i] - idx[i-1]), 32'd3);
    chk("t2_job_cnt", 32'(job_cnt), 32'd5);

    // Timeout on FFT with status never returned.
    resp_delay = 1000;
    push_evt(2'd0, 4'b0100);
    push_evt(2'd2, 4'b0100);
    start_log();
    do_job(4'b0100, 3'b010, 12);
    log_en = 1'b0;
    chk("t3_state_seq", st_seq(), 32'h01360);
    chk("t3_fft_cycles", 32'(en_count(1)), 32'd8);
    chk("t3_cic_cycles", 32'(en_count(0)), 32'd0);
    chk("t3_err_cycles", 32'(st_count(3'd6)), 32'd1);
    chk("t3_job_cnt", 32'(job_cnt), 32'd5);

    // Status arriving on the timeout cycle wins.
    resp_delay = 7;
    push_evt(2'd0, 4'b1000);
    push_evt(2'd1, 4'b1000);
    start_log();
    do_job(4'b1000, 3'b010, 12);
    log_en = 1'b0;
    chk("t4_state_seq", st_seq(), 32'h01350);
    chk("t4_fft_cycles", 32'(en_count(1)), 32'd8);
    chk("t4_job_cnt", 32'(job_cnt), 32'd6);

    // Skip FFT: FLT enable rises on the edge CIC falls.
    resp_delay = 3;
    push_evt(2'd0, 4'b0001);
    push_evt(2'd1, 4'b0001);
    start_log();
    do_job(4'b0001, 3'b101, 12);
    log_en = 1'b0;
    chk("t5_state_seq", st_seq(), 32'h012450);
    chk("t5_fft_cycles", 32'(en_count(1)), 32'd0);
    chk("t5_cic_cycles", 32'(en_count(0)), 32'd4);
    chk("t5_flt_cycles", 32'(en_count(2)), 32'd4);
    chk("t5_no_gap", 32'(first_hi(2)), 32'(last_hi(0) + 1));
    chk("t5_job_cnt", 32'(job_cnt), 32'd7);

    // Asynchronous reset during FLT aborts the job silently.
    resp_delay = 1000;
    push_evt(2'd0, 4'b0010);
    do_job(4'b0010, 3'b100, 0);
    repeat (2) @(posedge clk);
    #3;
    chk("t6_in_flt", 32'(bus.en_flt_o), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t6_async_enables", 32'({bus.en_cic_o, bus.en_fft_o, bus.en_flt_o}), 32'd0);
    chk("t6_async_busy", 32'(busy), 32'd0);
    chk("t6_async_state", 32'(state), 32'd0);
    chk("t6_async_job_cnt", 32'(job_cnt), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_after", 32'(state), 32'd0);

    // Enable low blocks grants while a request is pending.
    en = 1'b0;
    start_log();
    bus.stage_mask_i = 3'b000;
    bus.req_i        = 4'b0001;
    repeat (6) @(posedge clk);
    #1 log_en = 1'b0;
    acks = 0;
    foreach (ack_log[i]) if (ack_log[i]) acks++;
    chk("t7_no_ack_disabled", 32'(acks), 32'd0);
    chk("t7_idle_disabled", 32'(st_count(3'd0)), 32'd6);
    push_evt(2'd0, 4'b0001);
    push_evt(2'd1, 4'b0001);
    en = 1'b1;
    do_job(4'b0001, 3'b000, 3);
    chk("t7_job_cnt", 32'(job_cnt), 32'd1);

    // Counter wrap at 2^CNT_W-1 -> 0.
    for (int j = 0; j < 14; j++) begin
      push_evt(2'd0, 4'b0001);
      push_evt(2'd1, 4'b0001);
      do_job(4'b0001, 3'b000, 3);
    end
    chk("t8_cnt_max", 32'(job_cnt), 32'hF);
    push_evt(2'd0, 4'b0001);
    push_evt(2'd1, 4'b0001);
    do_job(4'b0001, 3'b000, 3);
    chk("t8_cnt_wrap", 32'(job_cnt), 32'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
